// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate front end: gate state encoding,
// gate indices and default timing parameters.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        DENIED = 2'd2,
        EMIT   = 2'd3
    } gate_state_t;

    localparam int SLOT_W_DEF       = 4;
    localparam int DEBOUNCE_DEF     = 4;
    localparam int OPEN_TIMEOUT_DEF = 50;

    localparam int NUM_GATES  = 2;
    localparam int GATE_ENTRY = 0;
    localparam int GATE_EXIT  = 1;

endpackage

// File: rtl/gate_fsm.sv
// One barrier gate: 2-FF sensor synchroniser, debounce, gate FSM and
// open-timeout counter. Barrier and pulse are registered.
module gate_fsm
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int OPEN_TIMEOUT    = OPEN_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor,
    input  logic enable_entry,
    input  logic hold,
    output logic barrier,
    output logic pulse,
    output logic timeout,
    output logic emitting
);

    localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(OPEN_TIMEOUT - 1);
    localparam logic [15:0] TO_MAX  = 16'(OPEN_TIMEOUT);

    logic        sync_q1, sync_q2;
    logic        acc_q;
    logic [7:0]  db_cnt_q;
    logic [15:0] to_cnt_q, to_cnt_d;
    gate_state_t state_q, state_d;
    logic        barrier_d, pulse_d;
    logic        differ, accept, rise_evt, fall_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sensor;
            sync_q2 <= sync_q1;
        end
    end

    // The edge is acted on in the same cycle the count completes, so the
    // FSM sees it without an extra register stage.
    assign differ   = (sync_q2 != acc_q);
    assign accept   = differ && (db_cnt_q == DB_LAST);
    assign rise_evt = accept &&  sync_q2;
    assign fall_evt = accept && !sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= 1'b0;
            db_cnt_q <= '0;
        end else if (!differ) begin
            db_cnt_q <= '0;
        end else if (accept) begin
            acc_q    <= sync_q2;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        pulse_d  = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_evt)
                    state_d = enable_entry ? OPEN : DENIED;
            end
            OPEN: begin
                to_cnt_d = (to_cnt_q == TO_MAX) ? TO_MAX : to_cnt_q + 16'd1;
                if (fall_evt) begin
                    state_d = EMIT;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
            DENIED: begin
                if (fall_evt)
                    state_d = IDLE;
            end
            EMIT: begin
                if (!hold) begin
                    state_d = IDLE;
                    pulse_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        barrier_d = (state_d == OPEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            barrier  <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            barrier  <= barrier_d;
            pulse    <= pulse_d;
        end
    end

    assign emitting = (state_q == EMIT);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate front end for parking_system: two gate instances, pulse
// arbitration (exit wins, entry stalls a cycle), full lamp and sticky fault.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int OPEN_TIMEOUT    = OPEN_TIMEOUT_DEF,
    parameter int SLOT_W          = SLOT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entry_sensor,
    input  logic              exit_sensor,
    input  logic [SLOT_W-1:0] free_slots,
    output logic              car_enter,
    output logic              car_leave,
    output logic              barrier_in,
    output logic              barrier_out,
    output logic              full_lamp,
    output logic              fault
);

    logic                 rst_meta, rst_sync;
    logic [NUM_GATES-1:0] sensor, enable, hold, barrier, pulse, timeout, emitting;

    // Asserts with reset, releases two clocks later on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_meta <= 1'b1;
            rst_sync <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_sync <= rst_meta;
        end
    end

    assign sensor[GATE_ENTRY] = entry_sensor;
    assign sensor[GATE_EXIT]  = exit_sensor;
    assign enable[GATE_ENTRY] = (free_slots != '0);
    assign enable[GATE_EXIT]  = 1'b1;

    // Only the entry gate is ever stalled, and only while both are emitting.
    assign hold[GATE_ENTRY] = emitting[GATE_ENTRY] && emitting[GATE_EXIT];
    assign hold[GATE_EXIT]  = 1'b0;

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        gate_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .OPEN_TIMEOUT    (OPEN_TIMEOUT)
        ) u_gate (
            .clk          (clk),
            .rst          (rst_sync),
            .sensor       (sensor[g]),
            .enable_entry (enable[g]),
            .hold         (hold[g]),
            .barrier      (barrier[g]),
            .pulse        (pulse[g]),
            .timeout      (timeout[g]),
            .emitting     (emitting[g])
        );
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            full_lamp <= 1'b0;
            fault     <= 1'b0;
        end else begin
            full_lamp <= (free_slots == '0);
            fault     <= fault | (|timeout);
        end
    end

    assign car_enter   = pulse[GATE_ENTRY];
    assign car_leave   = pulse[GATE_EXIT];
    assign barrier_in  = barrier[GATE_ENTRY];
    assign barrier_out = barrier[GATE_EXIT];

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Front-end producer for parking_system. Drives its car_enter / car_leave inputs.
- Takes raw, asynchronous beam-sensor levels from the entry and exit gates. Synchronises and debounces them.
- Drives the two barrier motors and emits exactly one single-cycle car_enter or car_leave pulse per completed passage.
- Uses free_slots fed back from parking_system to refuse entry when the lot is full.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed to accept a sensor edge (range 1..255).
- OPEN_TIMEOUT, 50: cycles a barrier may stay open waiting for the beam to clear before a fault abort (range 2..65535).
- SLOT_W, 4: width of the free_slots feedback.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- entry_sensor, input, 1: raw entry beam, 1 = vehicle present; asynchronous to clk.
- exit_sensor, input, 1: raw exit beam, 1 = vehicle present; asynchronous to clk.
- free_slots, input, SLOT_W: free-slot count from parking_system.
- car_enter, output, 1: one-cycle pulse per completed entry.
- car_leave, output, 1: one-cycle pulse per completed exit.
- barrier_in, output, 1: entry barrier open.
- barrier_out, output, 1: exit barrier open.
- full_lamp, output, 1: lot-full indicator.
- fault, output, 1: sticky timeout flag; cleared only by reset.

Behaviour:
- Reset: async assert, sync release. While reset is high, all outputs are 0, both gate FSMs are in IDLE, and the debounce and timeout counters are 0.
- Synchronisers: each sensor passes through a 2-FF synchroniser before any logic. Debounce counters operate on the synchronised signal only.
- Debounce: a level change is accepted when the synchronised value differs from the accepted value for DEBOUNCE_CYCLES consecutive cycles. Any bounce back restarts the count at 0.
- Gate FSM, one instance per gate. States are IDLE, OPEN, DENIED, EMIT.
  - IDLE, accepted rise, entry gate with free_slots == 0: go to DENIED. No barrier, no pulse.
  - IDLE, accepted rise, otherwise: go to OPEN. The barrier output rises on the same edge.
  - OPEN: the timeout counter increments every cycle.
  - OPEN, accepted fall: go to EMIT.
  - OPEN, counter reaches OPEN_TIMEOUT first: go to IDLE with no pulse, set fault, drop the barrier.
  - EMIT: the pulse is high for exactly 1 cycle and the barrier drops. Next state is IDLE.
  - DENIED: waits for an accepted fall, then returns to IDLE.
- Latency:
  - Raw sensor rise to barrier high = 2 + DEBOUNCE_CYCLES cycles (clean input).
  - Raw sensor fall to pulse high = 2 + DEBOUNCE_CYCLES + 1 cycles.
- full_lamp: registered, equals (free_slots == 0), one-cycle delay.
- Entry gating: free_slots is sampled only at the IDLE->OPEN decision. A count change while the entry barrier is open does not abort the entry.
- Simultaneous pulses: car_enter and car_leave are never high in the same cycle.
  - If both gates are in EMIT together, car_leave is issued first.
  - The entry gate holds in EMIT one extra cycle, so car_enter goes high the following cycle.
- Exit gate ignores free_slots. No underflow or overflow protection here; parking_system owns the count.
- Reset mid-operation: any open barrier drops immediately and any pending pulse is lost. fault is cleared.
- No counter wraps: the timeout counter saturates at OPEN_TIMEOUT, and the debounce counter saturates at DEBOUNCE_CYCLES.

Decomposition:
- Shared package parking_pkg holds:
  - gate-state encoding constants: IDLE = 2'd0, OPEN = 2'd1, DENIED = 2'd2, EMIT = 2'd3;
  - the SLOT_W default (4);
  - the default DEBOUNCE_CYCLES and OPEN_TIMEOUT values.
- Natural sub-module gate_fsm (synchroniser + debounce + FSM + timeout counter), instantiated twice.
  - Ports: enable_entry (free_slots != 0, tied to 1 for the exit gate), hold (arbitration stall), barrier, pulse, timeout.
- The top level contains only the arbitration, full_lamp and the fault register.

Test Plan:
- Reset, free_slots = 4, clean entry_sensor high for 20 cycles then low. Required: barrier_in rises 6 cycles after the raw rise; car_enter is high for exactly 1 cycle, 7 cycles after the raw fall; barrier_in is low in that cycle.
- entry_sensor toggles every 2 cycles for 20 cycles, then settles low. Required: barrier_in stays 0 and car_enter stays 0 throughout.
- free_slots = 0, entry_sensor high 20 cycles then low. Required: full_lamp = 1, barrier_in = 0, no car_enter pulse. Then free_slots = 1 and a new entry: the normal pulse appears.
- Entry and exit sensors dropped on the same cycle, both barriers open. Required: car_leave pulse at cycle N, car_enter pulse at cycle N+1, never overlapping.
- exit_sensor held high for 60 cycles with OPEN_TIMEOUT = 50. Required: barrier_out drops at timeout, fault = 1, no car_leave pulse, fault persists until reset.
- Reset asserted while barrier_in is open. Required: barrier_in drops asynchronously and no car_enter pulse follows after release.
